axi4_lite_cmd_master: RTL

Single-outstanding AXI4-Lite master that turns a valid/ready command stream into AXI4-Lite write or read transactions on the bus of the register/cache slave. Sits directly upstream of that slave and is driven by the test sequencer or host-side control logic. Returns one response beat per command, carrying read data and the bus response code.

---
 rtl/axi4_lite_cmd_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_cmd_master
//  Brief    : Single-outstanding AXI4-Lite master. Converts a valid/ready
//             command stream into AXI4-Lite write/read transactions and
//             returns one response beat per command.
//  Options  : AXI_CMD_MASTER_ALIGN_CHECK_EN - reject misaligned addresses
//             locally with SLVERR instead of issuing a bus transaction.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_cmd_master #(
   parameter logic [2:0] AXI_PROT  = 3'b000,
   parameter logic [3:0] FULL_STRB = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   // command stream
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   // response stream
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   output logic        rsp_write,
   // AXI write address channel
   output logic [31:0] awaddr,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   // AXI write data channel
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   // AXI write response channel
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   // AXI read address channel
   output logic [31:0] araddr,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI read data channel
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_WRESP = 3'd2,
      S_RD    = 3'd3,
      S_RDATA = 3'd4,
      S_RSP   = 3'd5
   } state_t;

   localparam logic [1:0] c_RESP_SLVERR = 2'b10;

   state_t      r_state;
   logic        r_aw_done;
   logic        r_w_done;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;

   logic        w_aw_fire;
   logic        w_w_fire;
   logic        w_aw_all;
   logic        w_w_all;
   logic        w_misaligned;
   logic [3:0]  w_strb;

   // Only one transaction in flight: commands are taken only when idle.
   assign cmd_ready = !rst && (r_state == S_IDLE);

   assign awprot = AXI_PROT;
   assign arprot = AXI_PROT;
   assign awaddr = r_addr;
   assign araddr = r_addr;
   assign wdata  = r_wdata;
   assign wstrb  = r_wstrb;

   // An all-zero strobe from the command side means "full word".
   assign w_strb = (cmd_wstrb == 4'h0) ? FULL_STRB : cmd_wstrb;

   assign w_aw_fire = awvalid && awready;
   assign w_w_fire  = wvalid && wready;
   assign w_aw_all  = r_aw_done || w_aw_fire;
   assign w_w_all   = r_w_done || w_w_fire;

`ifdef AXI_CMD_MASTER_ALIGN_CHECK_EN
   assign w_misaligned = (cmd_addr[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   // Transaction sequencer: all bus and response outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_wstrb   <= 4'h0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_resp  <= 2'b00;
         rsp_write <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_addr  <= cmd_addr;
                  r_wdata <= cmd_wdata;
                  r_wstrb <= w_strb;
                  if (w_misaligned) begin
                     // Local error: no bus activity, answer straight away.
                     rsp_valid <= 1'b1;
                     rsp_rdata <= 32'd0;
                     rsp_resp  <= c_RESP_SLVERR;
                     rsp_write <= cmd_write;
                     r_state   <= S_RSP;
                  end else if (cmd_write) begin
                     awvalid   <= 1'b1;
                     wvalid    <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                     r_state   <= S_WR;
                  end else begin
                     arvalid <= 1'b1;
                     r_state <= S_RD;
                  end
               end
            end
            S_WR: begin
               // AW and W complete independently, in either order.
               if (w_aw_fire) begin
                  awvalid   <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_fire) begin
                  wvalid   <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_all && w_w_all) begin
                  bready  <= 1'b1;
                  r_state <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (bvalid) begin
                  bready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= 32'd0;
                  rsp_resp  <= bresp;
                  rsp_write <= 1'b1;
                  r_state   <= S_RSP;
               end
            end
            S_RD: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  r_state <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (rvalid) begin
                  rready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rdata;
                  rsp_resp  <= rresp;
                  rsp_write <= 1'b0;
                  r_state   <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
